// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: the CPU has fixed priority,
// debug has a starvation guard, and only one access is in flight at a time.
module dmem_arbiter #(
  parameter int NB_ADDR      = 32,
  parameter int NB_WORD      = 32,
  parameter int RD_LATENCY   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_cpu_req,
  input  logic               i_cpu_wr,
  input  logic [NB_ADDR-1:0] i_cpu_addr,
  input  logic [NB_WORD-1:0] i_cpu_wdata,
  output logic               o_cpu_gnt,
  output logic               o_cpu_rvalid,
  output logic [NB_WORD-1:0] o_cpu_rdata,
  input  logic               i_dbg_req,
  input  logic               i_dbg_wr,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  input  logic [NB_WORD-1:0] i_dbg_wdata,
  output logic               o_dbg_gnt,
  output logic               o_dbg_rvalid,
  output logic [NB_WORD-1:0] o_dbg_rdata,
  output logic               o_mem_en,
  output logic               o_mem_wr,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_WORD-1:0] o_mem_wdata,
  input  logic [NB_WORD-1:0] i_mem_rdata,
  output logic               o_busy,
  output logic [1:0]         o_state
);

  // Handshake: a requester holds req (and its wr/addr/wdata) until a one-cycle gnt;
  // gnt fires only in IDLE, and the command is latched on that same clock edge.

  localparam int SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int WC_W = $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nx;
  logic              owner;      // 0 = CPU, 1 = debug
  logic              lat_wr;
  logic [SC_W-1:0]   starve_cnt;
  logic [WC_W-1:0]   wait_cnt;
  logic              starve_hit;
  logic              sel_wr;
  logic [NB_ADDR-1:0] sel_addr;
  logic [NB_WORD-1:0] sel_wdata;

  assign starve_hit = (STARVE_LIMIT != 0) && (starve_cnt == SC_W'(STARVE_LIMIT));

  always_comb begin
    state_nx  = state;
    o_cpu_gnt = 1'b0;
    o_dbg_gnt = 1'b0;
    case (state)
      IDLE: begin
        if (i_dbg_req && (!i_cpu_req || starve_hit)) begin
          o_dbg_gnt = 1'b1;
          state_nx  = ISSUE;
        end else if (i_cpu_req) begin
          o_cpu_gnt = 1'b1;
          state_nx  = ISSUE;
        end
      end
      ISSUE:   state_nx = lat_wr ? IDLE : WAIT;
      WAIT:    if (wait_cnt == WC_W'(1)) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sel_wr    = o_dbg_gnt ? i_dbg_wr    : i_cpu_wr;
    sel_addr  = o_dbg_gnt ? i_dbg_addr  : i_cpu_addr;
    sel_wdata = o_dbg_gnt ? i_dbg_wdata : i_cpu_wdata;
  end

  assign o_busy       = (state != IDLE);
  assign o_cpu_rvalid = (state == RESP) && !owner;
  assign o_dbg_rvalid = (state == RESP) && owner;
  assign o_state      = state;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      lat_wr      <= 1'b0;
      starve_cnt  <= '0;
      wait_cnt    <= '0;
      o_mem_en    <= 1'b0;
      o_mem_wr    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_cpu_rdata <= '0;
      o_dbg_rdata <= '0;
    end else begin
      state       <= state_nx;
      // Memory strobe is registered so it is high exactly in ISSUE and zero elsewhere.
      o_mem_en    <= 1'b0;
      o_mem_wr    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      if (o_cpu_gnt || o_dbg_gnt) begin
        owner       <= o_dbg_gnt;
        lat_wr      <= sel_wr;
        o_mem_en    <= 1'b1;
        o_mem_wr    <= sel_wr;
        o_mem_addr  <= sel_addr;
        o_mem_wdata <= sel_wdata;
      end

      if (o_dbg_gnt) begin
        starve_cnt <= '0;
      end else if (o_cpu_gnt && i_dbg_req) begin
        if (starve_cnt != SC_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + SC_W'(1);
      end else if (state == IDLE && !i_dbg_req) begin
        starve_cnt <= '0;
      end

      if (state == ISSUE && !lat_wr) wait_cnt <= WC_W'(RD_LATENCY);
      if (state == WAIT) begin
        wait_cnt <= wait_cnt - WC_W'(1);
        if (wait_cnt == WC_W'(1)) begin
          if (owner) o_dbg_rdata <= i_mem_rdata;
          else       o_cpu_rdata <= i_mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with default parameters and one with
// RD_LATENCY=1 / STARVE_LIMIT=0, both fed from the same stimulus.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_wr, dbg_req, dbg_wr;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;

  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_wr, busy;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
  logic [1:0]  state;

  logic        cpu_gnt_b, cpu_rvalid_b, dbg_gnt_b, dbg_rvalid_b, mem_en_b, mem_wr_b, busy_b;
  logic [31:0] cpu_rdata_b, dbg_rdata_b, mem_addr_b, mem_wdata_b;
  logic [1:0]  state_b;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [0:0]  exp_q[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.NB_ADDR(32), .NB_WORD(32), .RD_LATENCY(2), .STARVE_LIMIT(4)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_cpu_req(cpu_req), .i_cpu_wr(cpu_wr), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_gnt(cpu_gnt), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
    .i_dbg_req(dbg_req), .i_dbg_wr(dbg_wr), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata),
    .o_mem_en(mem_en), .o_mem_wr(mem_wr), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_busy(busy), .o_state(state)
  );

  dmem_arbiter #(.NB_ADDR(32), .NB_WORD(32), .RD_LATENCY(1), .STARVE_LIMIT(0)) dut_b (
    .i_clock(clk), .i_reset(rst),
    .i_cpu_req(cpu_req), .i_cpu_wr(cpu_wr), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_gnt(cpu_gnt_b), .o_cpu_rvalid(cpu_rvalid_b), .o_cpu_rdata(cpu_rdata_b),
    .i_dbg_req(dbg_req), .i_dbg_wr(dbg_wr), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_gnt(dbg_gnt_b), .o_dbg_rvalid(dbg_rvalid_b), .o_dbg_rdata(dbg_rdata_b),
    .o_mem_en(mem_en_b), .o_mem_wr(mem_wr_b), .o_mem_addr(mem_addr_b), .o_mem_wdata(mem_wdata_b),
    .i_mem_rdata(mem_rdata), .o_busy(busy_b), .o_state(state_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each cycle: inputs change 1 time unit after posedge, outputs checked 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_wr = 0; dbg_addr = 0; dbg_wdata = 0;
    mem_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] want_addr;
    logic        chk_addr;
    int          b_cpu, b_dbg;

    // Reset state of both instances
    do_reset();
    settle();
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_state", state, 0);
    chk("rst_b_busy", busy_b, 0);

    // CPU write 0x100 <- 0xDEADBEEF
    cpu_req = 1; cpu_wr = 1; cpu_addr = 32'h100; cpu_wdata = 32'hDEADBEEF;
    settle();
    chk("t1_gnt", cpu_gnt, 1);
    chk("t1_dbg_gnt", dbg_gnt, 0);
    step(); cpu_req = 0; cpu_addr = 0; cpu_wdata = 0; settle();
    chk("t1_mem_en", mem_en, 1);
    chk("t1_mem_wr", mem_wr, 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("t1_busy_issue", busy, 1);
    step(); settle();
    chk("t1_busy_done", busy, 0);
    chk("t1_mem_en_off", mem_en, 0);

    // CPU read 0x100 (latency 2) with a debug write arriving during WAIT
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h100;
    settle();
    chk("t2_gnt", cpu_gnt, 1);
    step(); cpu_req = 0; settle();
    chk("t2_mem_en", mem_en, 1);
    chk("t2_mem_wr", mem_wr, 0);
    step();
    mem_rdata = 32'h11111111;
    dbg_req = 1; dbg_wr = 1; dbg_addr = 32'h200; dbg_wdata = 32'h55;
    settle();
    chk("t4_no_gnt_wait1", dbg_gnt, 0);
    chk("t2_no_rvalid_early", cpu_rvalid, 0);
    step(); mem_rdata = 32'hDEADBEEF; settle();
    chk("t4_no_gnt_wait2", dbg_gnt, 0);
    step(); mem_rdata = 32'h22222222; settle();
    chk("t2_rvalid", cpu_rvalid, 1);
    chk("t2_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("t2_dbg_rvalid", dbg_rvalid, 0);
    chk("t4_no_gnt_resp", dbg_gnt, 0);
    step(); settle();
    chk("t4_dbg_gnt_idle", dbg_gnt, 1);
    chk("t4_cpu_gnt_idle", cpu_gnt, 0);
    chk("t2_rvalid_pulse", cpu_rvalid, 0);
    chk("t2_rdata_hold", cpu_rdata, 32'hDEADBEEF);
    chk("t2_dbg_rdata", dbg_rdata, 0);
    step(); dbg_req = 0; dbg_addr = 0; dbg_wdata = 0; settle();
    chk("t4_mem_en", mem_en, 1);
    chk("t4_mem_wr", mem_wr, 1);
    chk("t4_mem_addr", mem_addr, 32'h200);
    chk("t4_mem_wdata", mem_wdata, 32'h55);

    // Both ports request continuously: CPU x4, DBG, CPU x4, DBG
    do_reset();
    for (int i = 0; i < 10; i++) exp_q.push_back((i == 4 || i == 9) ? 1'b1 : 1'b0);
    cpu_req = 1; cpu_wr = 1; cpu_addr = 32'hC0; cpu_wdata = 32'h1;
    dbg_req = 1; dbg_wr = 1; dbg_addr = 32'hD0; dbg_wdata = 32'h2;
    chk_addr = 0; want_addr = 0; b_cpu = 0; b_dbg = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      settle();
      if (chk_addr) chk("t3_mem_addr", mem_addr, want_addr);
      chk_addr = 0;
      chk("t3_one_gnt", cpu_gnt & dbg_gnt, 0);
      if (cpu_gnt || dbg_gnt) begin
        if (exp_q.size() == 0) begin
          chk("t3_extra_gnt", cpu_gnt | dbg_gnt, 0);
        end else begin
          chk("t3_order", dbg_gnt, exp_q.pop_front());
          want_addr = dbg_gnt ? 32'hD0 : 32'hC0;
          chk_addr = 1;
        end
      end
      b_cpu += int'(cpu_gnt_b);
      b_dbg += int'(dbg_gnt_b);
      step();
    end
    chk("t3_grants_left", exp_q.size(), 0);
    chk("t3_b_cpu_grants", b_cpu, 10);
    chk("t3_b_dbg_grants", b_dbg, 0);

    // Reset pulsed during WAIT of a read discards it
    do_reset();
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h300; mem_rdata = 32'h77;
    settle();
    chk("t5_gnt", cpu_gnt, 1);
    step(); cpu_req = 0; cpu_addr = 0;
    step(); settle();
    chk("t5_in_wait", state, 2);
    rst = 1;
    step(); rst = 0; settle();
    chk("t5_state", state, 0);
    chk("t5_busy", busy, 0);
    chk("t5_mem_en", mem_en, 0);
    chk("t5_mem_addr", mem_addr, 0);
    chk("t5_cpu_rdata", cpu_rdata, 0);
    chk("t5_cpu_gnt", cpu_gnt, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t5_no_rvalid", cpu_rvalid | dbg_rvalid, 0);
      step(); settle();
    end

    // RD_LATENCY=1 read timing, then back-to-back writes, on the second instance
    do_reset();
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h400; mem_rdata = 32'h1111;
    settle();
    chk("t6_gnt", cpu_gnt_b, 1);
    step(); cpu_req = 0; settle();
    chk("t6_mem_en", mem_en_b, 1);
    chk("t6_mem_addr", mem_addr_b, 32'h400);
    step(); mem_rdata = 32'hCAFEF00D; settle();
    chk("t6_no_rvalid_early", cpu_rvalid_b, 0);
    step(); mem_rdata = 32'h2222; settle();
    chk("t6_rvalid", cpu_rvalid_b, 1);
    chk("t6_rdata", cpu_rdata_b, 32'hCAFEF00D);
    step();
    cpu_req = 1; cpu_wr = 1; cpu_addr = 32'h500; cpu_wdata = 32'h9;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("t6_b2b_gnt", cpu_gnt_b, (k % 2 == 0) ? 1 : 0);
      chk("t6_b2b_mem_en", mem_en_b, (k % 2 == 1) ? 1 : 0);
      step();
    end
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
